// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use, multi-cycle
// data-memory and taken-branch hazards, and keeps a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT  = 64,
    parameter bit R0_HARDWIRED = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       rs1_decode,
    input  logic [3:0]       rs2_decode,
    input  logic [3:0]       rd_execute,
    input  logic             load_execute,
    input  logic             wre_execute,
    input  logic             vector_wre_execute,
    input  logic             branch_taken_execute,
    input  logic             mem_request_memory,
    input  logic             mem_ready,
    input  logic             stall_cnt_clear,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             bubble_execute,
    output logic             flush_decode,
    output logic             stall_memory,
    output logic             bubble_writeback,
    output logic             mem_timeout,
    output logic [1:0]       busy_state,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ABORT    = 2'b10
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_next;
    logic        timeout_set;
    logic        run_rules;

    logic        rd_match;
    logic        rd_nonzero;
    logic        load_use;
    logic        mem_busy;
    logic        mem_done;

    logic        sf_c;
    logic        sd_c;
    logic        bx_c;
    logic        fd_c;
    logic        sm_c;
    logic        bw_c;

    assign rd_match   = (rd_execute == rs1_decode) || (rd_execute == rs2_decode);
    assign rd_nonzero = !R0_HARDWIRED || (rd_execute != 4'd0);
    assign load_use   = load_execute && (wre_execute || vector_wre_execute) && rd_match && rd_nonzero;
    assign mem_busy   = mem_request_memory && !mem_ready;
    assign mem_done   = mem_request_memory && mem_ready;

    // The ready cycle of a memory wait falls back onto the RUN rules so that
    // branches and load-use hazards held behind the stall resolve immediately.
    always_comb begin
        next_state    = state;
        wait_cnt_next = wait_cnt;
        timeout_set   = 1'b0;
        run_rules     = 1'b0;
        sf_c          = 1'b0;
        sd_c          = 1'b0;
        bx_c          = 1'b0;
        fd_c          = 1'b0;
        sm_c          = 1'b0;
        bw_c          = 1'b0;

        case (state)
            RUN: begin
                run_rules = 1'b1;
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    run_rules = 1'b1;
                end else begin
                    sf_c = 1'b1;
                    sd_c = 1'b1;
                    sm_c = 1'b1;
                    bw_c = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        next_state  = ABORT;
                        timeout_set = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt + 16'd1;
                    end
                end
            end
            ABORT: begin
                sf_c          = 1'b1;
                bw_c          = 1'b1;
                next_state    = RUN;
                wait_cnt_next = 16'd0;
            end
            default: begin
                next_state    = RUN;
                wait_cnt_next = 16'd0;
            end
        endcase

        if (run_rules) begin
            if (mem_busy) begin
                sf_c          = 1'b1;
                sd_c          = 1'b1;
                sm_c          = 1'b1;
                bw_c          = 1'b1;
                next_state    = MEM_WAIT;
                wait_cnt_next = 16'd1;
            end else begin
                next_state    = RUN;
                wait_cnt_next = 16'd0;
                if (branch_taken_execute) begin
                    fd_c = 1'b1;
                    bx_c = 1'b1;
                end else if (load_use) begin
                    sf_c = 1'b1;
                    sd_c = 1'b1;
                    bx_c = 1'b1;
                end
            end
        end
    end

    // Gating with reset keeps every control low while reset is held, even
    // though the hazard inputs themselves may still be toggling.
    assign stall_fetch      = reset && sf_c;
    assign stall_decode     = reset && sd_c;
    assign bubble_execute   = reset && bx_c;
    assign flush_decode     = reset && fd_c;
    assign stall_memory     = reset && sm_c;
    assign bubble_writeback = reset && bw_c;
    assign busy_state       = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_timeout <= 1'b0;
        end else if (timeout_set) begin
            mem_timeout <= 1'b1;
        end
    end

    // Clear wins over increment; the counter parks at all-ones once full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall_cnt_clear) begin
            stall_cycles <= '0;
        end else if (sf_c && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and randomized bench for pipeline_hazard_controller, compared every
// cycle against a cycle-level model built from the hazard rules.
module tb_pipeline_hazard_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 6;
    localparam int SAT         = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       rs1_decode, rs2_decode, rd_execute;
    logic             load_execute, wre_execute, vector_wre_execute;
    logic             branch_taken_execute, mem_request_memory, mem_ready, stall_cnt_clear;
    logic             stall_fetch, stall_decode, bubble_execute, flush_decode;
    logic             stall_memory, bubble_writeback, mem_timeout;
    logic [1:0]       busy_state;
    logic [CNT_W-1:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    // reference model: 0 = running, 1 = waiting on memory, 2 = abort cycle
    int m_phase;
    int m_waited;
    int m_timeout;
    int m_count;

    pipeline_hazard_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .R0_HARDWIRED(1'b1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .rs1_decode          (rs1_decode),
        .rs2_decode          (rs2_decode),
        .rd_execute          (rd_execute),
        .load_execute        (load_execute),
        .wre_execute         (wre_execute),
        .vector_wre_execute  (vector_wre_execute),
        .branch_taken_execute(branch_taken_execute),
        .mem_request_memory  (mem_request_memory),
        .mem_ready           (mem_ready),
        .stall_cnt_clear     (stall_cnt_clear),
        .stall_fetch         (stall_fetch),
        .stall_decode        (stall_decode),
        .bubble_execute      (bubble_execute),
        .flush_decode        (flush_decode),
        .stall_memory        (stall_memory),
        .bubble_writeback    (bubble_writeback),
        .mem_timeout         (mem_timeout),
        .busy_state          (busy_state),
        .stall_cycles        (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                                  input logic ld, input logic wre, input logic vwre, input logic br,
                                  input logic req, input logic rdy, input logic clr);
        rs1_decode           = rs1;
        rs2_decode           = rs2;
        rd_execute           = rd;
        load_execute         = ld;
        wre_execute          = wre;
        vector_wre_execute   = vwre;
        branch_taken_execute = br;
        mem_request_memory   = req;
        mem_ready            = rdy;
        stall_cnt_clear      = clr;
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_waited  = 0;
        m_timeout = 0;
        m_count   = 0;
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance it.
    task automatic step();
        bit e_sf, e_sd, e_bx, e_fd, e_sm, e_bw, lu, busy, done;
        int n_phase, n_waited, n_timeout, n_count;
        @(negedge clk);
        {e_sf, e_sd, e_bx, e_fd, e_sm, e_bw} = '0;
        n_phase   = m_phase;
        n_waited  = m_waited;
        n_timeout = m_timeout;
        lu   = load_execute && (wre_execute || vector_wre_execute) && (rd_execute != 0) &&
               ((rd_execute == rs1_decode) || (rd_execute == rs2_decode));
        busy = mem_request_memory && !mem_ready;
        done = mem_request_memory && mem_ready;
        if (m_phase == 2) begin
            e_sf = 1; e_bw = 1; n_phase = 0;
        end else if (m_phase == 1 && !done) begin
            e_sf = 1; e_sd = 1; e_sm = 1; e_bw = 1;
            if (m_waited + 1 >= MEM_TIMEOUT) begin
                n_phase = 2; n_timeout = 1;
            end else begin
                n_waited = m_waited + 1;
            end
        end else begin
            n_phase = 0;
            if (busy) begin
                e_sf = 1; e_sd = 1; e_sm = 1; e_bw = 1; n_phase = 1; n_waited = 1;
            end else if (branch_taken_execute) begin
                e_fd = 1; e_bx = 1;
            end else if (lu) begin
                e_sf = 1; e_sd = 1; e_bx = 1;
            end
        end
        if (stall_cnt_clear) n_count = 0;
        else if (e_sf)       n_count = (m_count + 1 > SAT) ? SAT : m_count + 1;
        else                 n_count = m_count;

        if (!reset) begin
            {e_sf, e_sd, e_bx, e_fd, e_sm, e_bw} = '0;
            model_reset();
            n_phase = 0; n_waited = 0; n_timeout = 0; n_count = 0;
        end
        check_output("stall_fetch", 32'(stall_fetch), 32'(e_sf));
        check_output("stall_decode", 32'(stall_decode), 32'(e_sd));
        check_output("bubble_execute", 32'(bubble_execute), 32'(e_bx));
        check_output("flush_decode", 32'(flush_decode), 32'(e_fd));
        check_output("stall_memory", 32'(stall_memory), 32'(e_sm));
        check_output("bubble_writeback", 32'(bubble_writeback), 32'(e_bw));
        check_output("busy_state", 32'(busy_state), 32'(m_phase));
        check_output("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
        check_output("stall_cycles", 32'(stall_cycles), 32'(m_count));
        @(posedge clk);
        m_phase   = n_phase;
        m_waited  = n_waited;
        m_timeout = n_timeout;
        m_count   = n_count;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        apply_stimulus(4'd0, 4'd5, 4'd5, 1, 1, 0, 0, 0, 0, 0);
        model_reset();
        step();
        step();
        reset = 1'b1;
        apply_stimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("[TB] load-use on r5, then on r0");
        apply_stimulus(4'd1, 4'd5, 4'd5, 1, 1, 0, 0, 0, 0, 0);
        step();
        apply_stimulus(4'd1, 4'd5, 4'd6, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_output("tp1_count", 32'(stall_cycles), 32'd1);
        apply_stimulus(4'd0, 4'd0, 4'd0, 1, 1, 1, 0, 0, 0, 0);
        step();
        apply_stimulus(4'd3, 4'd0, 4'd3, 1, 0, 1, 0, 0, 0, 0);
        step();

        $display("[TB] memory wait with late ready");
        apply_stimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) step();
        mem_ready = 1'b1;
        step();
        apply_stimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 0);
        step();

        $display("[TB] watchdog abort");
        apply_stimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        repeat (6) step();
        apply_stimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1, 0);
        step();
        check_output("tp3_sticky", 32'(mem_timeout), 32'd1);

        $display("[TB] branch and load-use together");
        apply_stimulus(4'd7, 4'd2, 4'd7, 1, 1, 0, 1, 0, 0, 0);
        step();

        $display("[TB] branch held during memory wait");
        apply_stimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 1, 0, 0);
        repeat (2) step();
        mem_ready = 1'b1;
        step();
        apply_stimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) < 3),
                           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
            step();
        end

        $display("[TB] counter saturation and clear");
        apply_stimulus(4'd9, 4'd0, 4'd9, 1, 0, 1, 0, 0, 0, 1);
        step();
        stall_cnt_clear = 1'b0;
        repeat (SAT + 5) step();
        check_output("sat_count", 32'(stall_cycles), 32'(SAT));
        stall_cnt_clear = 1'b1;
        step();
        check_output("clear_count", 32'(stall_cycles), 32'd0);
        stall_cnt_clear = 1'b0;
        step();

        $display("[TB] asynchronous reset during memory wait");
        apply_stimulus(4'd4, 4'd4, 4'd4, 1, 1, 0, 1, 1, 0, 0);
        repeat (2) step();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_state", 32'(busy_state), 32'd0);
        check_output("async_ctrl", 32'({stall_fetch, stall_decode, bubble_execute, flush_decode,
                                        stall_memory, bubble_writeback}), 32'd0);
        check_output("async_timeout", 32'(mem_timeout), 32'd0);
        check_output("async_count", 32'(stall_cycles), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        step();
        reset = 1'b1;
        apply_stimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage scalar/vector pipeline. It drives the enable and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:
- load-use hazards;
- multi-cycle data-memory accesses, using a mem_ready handshake with a watchdog;
- taken-branch flushes.
It also keeps a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 64, max cycles spent in MEM_WAIT before the access is aborted (legal range 2..65535)
R0_HARDWIRED, 1, when 1, rd==0 never creates a load-use hazard
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
rs1_decode  in  4  source reg 1 of instruction in ID
rs2_decode  in  4  source reg 2 of instruction in ID
rd_execute  in  4  destination reg of instruction in EX
load_execute  in  1  instruction in EX is a scalar or vector load
wre_execute  in  1  instruction in EX writes scalar RF
vector_wre_execute  in  1  instruction in EX writes vector RF
branch_taken_execute  in  1  branch in EX resolved taken
mem_request_memory  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes the access this cycle
stall_cnt_clear  in  1  synchronous clear of stall_cycles
stall_fetch  out  1  hold PC and IF/ID
stall_decode  out  1  hold ID/EX inputs
bubble_execute  out  1  load NOP (all write enables 0) into ID/EX
flush_decode  out  1  load NOP into IF/ID
stall_memory  out  1  hold EX/MEM
bubble_writeback  out  1  force wre/vector_wre 0 into MEM/WB
mem_timeout  out  1  sticky, memory access aborted by watchdog
busy_state  out  2  current FSM state encoding
stall_cycles  out  CNT_W  saturating count of cycles with stall_fetch=1

Behaviour:
- State register and counters are clocked and asynchronously reset when reset=0.
- Control outputs are combinational from the current state and inputs, so a hazard is handled in the same cycle it is detected.
- Reset values:
  - state=RUN (busy_state=2'b00);
  - mem_timeout=0, stall_cycles=0, wait counter=0;
  - all control outputs 0 while reset is asserted.
- States: RUN=00, MEM_WAIT=01, ABORT=10.
- load_use condition:
  - load_execute & (wre_execute | vector_wre_execute) & (rd_execute==rs1_decode | rd_execute==rs2_decode);
  - additionally gated by rd_execute!=0 when R0_HARDWIRED=1.
- mem_busy = mem_request_memory & ~mem_ready.
- RUN:
  - if mem_busy: stall_fetch=stall_decode=stall_memory=bubble_writeback=1; next=MEM_WAIT; wait counter loads 1. Branch and load-use are ignored this cycle (EX is frozen and they re-evaluate later).
  - else if branch_taken_execute: flush_decode=1, bubble_execute=1. Load-use is ignored because the ID instruction is squashed.
  - else if load_use: stall_fetch=stall_decode=bubble_execute=1, for exactly one cycle per occurrence.
- MEM_WAIT:
  - same four stall outputs asserted.
  - if mem_ready: all outputs 0 this cycle; next=RUN; the MEM/WB capture of the memory data occurs on this edge. Pending branch/load-use conditions are evaluated normally in this same cycle under RUN rules.
  - else if wait counter==MEM_TIMEOUT-1: next=ABORT and mem_timeout is set.
  - else the wait counter increments.
- ABORT (exactly one cycle):
  - bubble_writeback=1 and stall_fetch=1 so the aborted result is never written back; stall_memory=0 so EX/MEM advances.
  - next=RUN unconditionally.
- mem_timeout is cleared only by reset.
- stall_cycles:
  - +1 on every cycle where stall_fetch=1;
  - saturates at all-ones;
  - stall_cnt_clear takes priority over increment (counter becomes 0).
- mem_ready while mem_request_memory=0 is ignored.
- Reset asserted mid-MEM_WAIT: immediate return to RUN; all outputs 0 asynchronously.

Test Plan:
1. Load r5 in EX (load_execute=1, wre_execute=1, rd_execute=5), rs2_decode=5 -> exactly 1 cycle of stall_fetch=stall_decode=bubble_execute=1; stall_cycles=1. Same case with rd_execute=0 -> no stall.
2. mem_request_memory=1 with mem_ready low for 3 cycles, then high -> stall_memory=bubble_writeback=1 for 3 cycles, 0 in the ready cycle; busy_state sequence 00,01,01,01->00; stall_cycles=3.
3. MEM_TIMEOUT=4, mem_ready never asserted -> 4 stall cycles, then ABORT for 1 cycle (bubble_writeback=1, stall_memory=0); mem_timeout=1 and stays 1 after further traffic.
4. branch_taken_execute=1 and load_use true in the same cycle -> flush_decode=bubble_execute=1, stall_fetch=0.
5. branch_taken_execute=1 during MEM_WAIT -> no flush until the mem_ready cycle, then flush_decode=1 in that cycle.
6. Force 2^CNT_W+5 stall cycles -> stall_cycles holds at all-ones; pulse stall_cnt_clear during a stall -> 0. Assert reset (0) mid-MEM_WAIT -> busy_state=00 and all outputs 0 without waiting for a clock edge.
